// File: rtl/iob_dbus_router.sv
// iob_dbus_router: address-decoded CPU data-bus router tracking one outstanding transaction.
// Define DBUS_TIMEOUT_EN to add a watchdog that terminates hung slave transactions.
module iob_dbus_router #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int N_SLAVES = 4,
    parameter int SEL_W    = 2,
    parameter int TIMEOUT  = 1024,
    localparam int REQ_W   = 1 + ADDR_W + DATA_W + DATA_W/8,
    localparam int RESP_W  = DATA_W + 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [REQ_W-1:0]             m_req,
    output logic [RESP_W-1:0]            m_resp,
    output logic [N_SLAVES*REQ_W-1:0]    s_req,
    input  logic [N_SLAVES*RESP_W-1:0]   s_resp,
    output logic [1:0]                   err
);
    typedef enum logic [1:0] {IDLE, BUSY, DERR} state_t;
    state_t state, state_n;
    logic [SEL_W-1:0] sel_reg, idx;
    logic [RESP_W-1:0] resp [2**SEL_W];
    logic [REQ_W-1:0] fwd;
    logic valid, dec, derr_q, tout_q, expire;
    assign valid = m_req[REQ_W-1];
    assign idx   = m_req[REQ_W-2 -: SEL_W];
    assign dec   = int'(idx) < N_SLAVES;
    assign fwd   = {valid && state == IDLE, m_req[REQ_W-2:0]};
    assign err   = {tout_q, derr_q};
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be >= 2");
    end
    // Unpopulated index slots read as an idle response so a stray index never returns ready.
    for (genvar k = 0; k < 2**SEL_W; k++) begin : g_slv
        if (k < N_SLAVES) begin : g_port
            assign resp[k] = s_resp[k*RESP_W +: RESP_W];
            assign s_req[k*REQ_W +: REQ_W] = (resetn && idx == SEL_W'(k)) ? fwd : '0;
        end else begin : g_pad
            assign resp[k] = '0;
        end
    end
    always_comb begin
        state_n = state;
        m_resp  = '0;
        case (state)
            IDLE: begin
                if (valid) state_n = !dec ? DERR : resp[idx][0] ? IDLE : BUSY;
                m_resp = (valid && dec && resp[idx][0]) ? resp[idx] : '0;
            end
            BUSY: begin
                if (resp[sel_reg][0]) begin
                    m_resp  = resp[sel_reg];
                    state_n = IDLE;
                end else if (expire) begin
                    m_resp  = {DATA_W'(32'hDEADBEEF), 1'b1};
                    state_n = IDLE;
                end
            end
            DERR: begin
                m_resp  = RESP_W'(1);
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (!resetn) m_resp = '0;
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            sel_reg <= '0;
            derr_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && valid && dec) sel_reg <= idx;
            if (state == IDLE && valid && !dec) derr_q <= 1'b1;
        end
    end
`ifdef DBUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0] timer;
    assign expire = state == BUSY && timer == TW'(TIMEOUT-1);
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer  <= '0;
            tout_q <= 1'b0;
        end else begin
            timer <= state == BUSY ? timer + 1'b1 : '0;
            if (expire && !resp[sel_reg][0]) tout_q <= 1'b1;
        end
    end
`else
    assign expire = 1'b0;
    assign tout_q = 1'b0;
`endif
endmodule

// File: tb/tb_iob_dbus_router.sv
// tb_iob_dbus_router: scoreboard bench for the data-bus router (3 slaves, TIMEOUT=8).
module tb_iob_dbus_router;
    localparam int ADDR_W = 32, DATA_W = 32, N_SLAVES = 3, SEL_W = 2, TIMEOUT = 8;
    localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W/8;
    localparam int RESP_W = DATA_W + 1;
    typedef struct {logic [RESP_W-1:0] resp; int cyc;} exp_t;
    logic clk = 1'b0, resetn = 1'b0;
    logic [REQ_W-1:0] m_req = '0;
    logic [RESP_W-1:0] m_resp;
    logic [N_SLAVES*REQ_W-1:0] s_req;
    logic [N_SLAVES*RESP_W-1:0] s_resp = '0;
    logic [1:0] err;
    exp_t sb[$];
    int n_tests = 0, n_fail = 0, cyc_n = 0, c0 = 0;

    iob_dbus_router #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_SLAVES(N_SLAVES),
                      .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .m_req(m_req), .m_resp(m_resp),
        .s_req(s_req), .s_resp(s_resp), .err(err));

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [REQ_W-1:0] mk_req(input logic v, input logic [31:0] a,
                                                 input logic [31:0] d, input logic [3:0] s);
        return {v, a, d, s};
    endfunction

    task automatic slv(input int k, input logic [31:0] d, input logic r);
        s_resp[k*RESP_W +: RESP_W] = {d, r};
    endtask

    task automatic expect_resp(input logic [31:0] d, input int c);
        exp_t e;
        e.resp = {d, 1'b1};
        e.cyc  = c;
        sb.push_back(e);
    endtask

    function automatic logic [N_SLAVES-1:0] vbits();
        logic [N_SLAVES-1:0] v;
        for (int k = 0; k < N_SLAVES; k++) v[k] = s_req[k*REQ_W + REQ_W - 1];
        return v;
    endfunction

    function automatic logic [N_SLAVES*REQ_W-1:0] exp_sreq(input int k, input logic [REQ_W-1:0] r);
        logic [N_SLAVES*REQ_W-1:0] v;
        v = '0;
        v[k*REQ_W +: REQ_W] = r;
        return v;
    endfunction

    // Every ready seen on the master side must match the oldest expectation, value and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && m_resp[0]) begin
            if (sb.size() == 0) chk("spurious_ready", m_resp, '0);
            else begin
                e = sb.pop_front();
                chk("resp_data", m_resp, e.resp);
                chk("resp_cycle", cyc_n, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick();
        m_req = mk_req(1'b1, 32'h4000_0010, 32'h1234_5678, 4'hF);
        slv(1, 32'hABCD_0000, 1'b1);
        mid();
        chk("rst_resp", m_resp, '0);
        chk("rst_sreq", s_req, '0);
        chk("rst_err", err, 2'b00);
        tick();
        resetn = 1'b1;
        m_req  = '0;
        s_resp = '0;
        // Write to slave 1, ready two cycles later
        tick();
        m_req = mk_req(1'b1, 32'h4000_0010, 32'h1234_5678, 4'hF);
        mid();
        chk("t2_sreq", s_req, exp_sreq(1, m_req));
        chk("t2_resp_idle", m_resp, '0);
        tick();
        m_req[REQ_W-1] = 1'b0;
        mid();
        chk("t2_busy_valid", vbits(), 3'b000);
        chk("t2_sel", dut.sel_reg, 2'd1);
        chk("t2_busy_resp", m_resp, '0);
        tick();
        slv(1, 32'h1111_0000, 1'b1);
        expect_resp(32'h1111_0000, cyc_n);
        mid();
        tick();
        slv(1, 32'h0, 1'b0);
        mid();
        chk("t2_idle_after", m_resp, '0);
        // Zero-latency read from slave 2, then a stray ready in IDLE
        tick();
        m_req = mk_req(1'b1, 32'h8000_0000, 32'h0, 4'h0);
        slv(2, 32'hCAFE_F00D, 1'b1);
        expect_resp(32'hCAFE_F00D, cyc_n);
        mid();
        chk("t3_sreq_valid", vbits(), 3'b100);
        tick();
        m_req[REQ_W-1] = 1'b0;
        mid();
        chk("t3_stray", m_resp, '0);
        // Decode error on index 3
        tick();
        slv(2, 32'h0, 1'b0);
        m_req = mk_req(1'b1, 32'hC000_0000, 32'hAAAA_AAAA, 4'hF);
        expect_resp(32'h0, cyc_n + 1);
        mid();
        chk("t4_sreq", s_req, '0);
        chk("t4_resp0", m_resp, '0);
        tick();
        m_req[REQ_W-1] = 1'b0;
        mid();
        chk("t4_err", err, 2'b01);
        // Glitch while BUSY, wrong-slave ready, then back-to-back request
        tick();
        m_req = mk_req(1'b1, 32'h8000_0004, 32'h5, 4'h3);
        mid();
        tick();
        m_req = mk_req(1'b1, 32'h0000_0008, 32'h6, 4'h1);
        slv(0, 32'h0BAD_0BAD, 1'b1);
        mid();
        chk("t5_glitch_valid", vbits(), 3'b000);
        chk("t5_glitch_resp", m_resp, '0);
        tick();
        m_req = mk_req(1'b0, 32'h8000_0004, 32'h5, 4'h3);
        slv(0, 32'h0, 1'b0);
        slv(2, 32'h2222_2222, 1'b1);
        expect_resp(32'h2222_2222, cyc_n);
        mid();
        tick();
        slv(2, 32'h0, 1'b0);
        m_req = mk_req(1'b1, 32'h4000_0020, 32'h7, 4'hF);
        slv(1, 32'h3333_3333, 1'b1);
        expect_resp(32'h3333_3333, cyc_n);
        mid();
        chk("t5_b2b_valid", vbits(), 3'b010);
        tick();
        m_req[REQ_W-1] = 1'b0;
        slv(1, 32'h0, 1'b0);
`ifdef DBUS_TIMEOUT_EN
        // Slave ready on the expiry cycle wins
        tick();
        m_req = mk_req(1'b1, 32'h0000_0000, 32'h9, 4'hF);
        c0 = cyc_n;
        expect_resp(32'h5555_5555, c0 + TIMEOUT);
        tick();
        m_req[REQ_W-1] = 1'b0;
        repeat (TIMEOUT - 1) tick();
        slv(0, 32'h5555_5555, 1'b1);
        mid();
        tick();
        slv(0, 32'h0, 1'b0);
        mid();
        chk("t6_ready_wins_err", err[1], 1'b0);
        tick();
        m_req = mk_req(1'b1, 32'h0000_0004, 32'hA, 4'hF);
        c0 = cyc_n;
        expect_resp(32'hDEAD_BEEF, c0 + TIMEOUT);
        tick();
        m_req[REQ_W-1] = 1'b0;
        repeat (TIMEOUT) tick();
        mid();
        chk("t6_timeout_err", err, 2'b11);
`else
        // Without the watchdog a silent slave keeps the router BUSY
        tick();
        m_req = mk_req(1'b1, 32'h0000_0000, 32'h9, 4'hF);
        tick();
        m_req[REQ_W-1] = 1'b0;
        repeat (12) tick();
        mid();
        chk("t6_hold", m_resp, '0);
        tick();
        slv(0, 32'h5555_5555, 1'b1);
        expect_resp(32'h5555_5555, cyc_n);
        mid();
        tick();
        slv(0, 32'h0, 1'b0);
        mid();
        chk("t6_no_tout_err", err, 2'b01);
`endif
        // Reset while BUSY, late slave ready afterwards
        tick();
        m_req = mk_req(1'b1, 32'h4000_0000, 32'h77, 4'hF);
        mid();
        tick();
        resetn = 1'b0;
        mid();
        chk("t1_resp", m_resp, '0);
        chk("t1_sreq", s_req, '0);
        chk("t1_err", err, 2'b00);
        tick();
        resetn = 1'b1;
        m_req  = '0;
        slv(1, 32'hFFFF_FFFF, 1'b1);
        mid();
        chk("t1_late", m_resp, '0);
        tick();
        slv(1, 32'h0, 1'b0);
        mid();
        chk("sb_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
